// File: rtl/serial_sub_if.sv
// Controller-side bundle for serial_sub: operand request, status and held result.
// start is a request, not a valid/ready pair: it is taken on any rising edge where busy is low, ignored while busy, and each accepted request yields exactly one done pulse.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bor;
    logic [1:0]       fsm_state;

    modport master (
        output start, a, b,
        input  busy, done, diff, bor, fsm_state
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bor, fsm_state
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// using a full-subtract cell made of two half_sub cells and a registered borrow.
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);
    assign d    = x ^ y;
    assign bout = ~x & y;
endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    serial_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             bor_q;
    logic [CW-1:0]    cnt;
    logic             d1;
    logic             b1;
    logic             d;
    logic             b2;
    logic             br_n;
    logic             accept;
    logic             last;

    half_sub u_hs0 (.x(sa[0]), .y(sb[0]), .d(d1), .bout(b1));
    half_sub u_hs1 (.x(d1),    .y(br),    .d(d),  .bout(b2));
    assign br_n = b1 | b2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        accept  = 1'b0;
        last    = 1'b0;
        state_n = state;
        case (state)
            IDLE: begin
                accept = bus.start;
                if (accept) state_n = SHIFT;
            end
            SHIFT: begin
                last = (cnt == LAST);
                if (last) state_n = DONE;
            end
            DONE: begin
                accept  = bus.start;
                state_n = accept ? SHIFT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Result registers load only on the final bit so the previous answer stays visible during SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bor_q  <= 1'b0;
        end else if (accept) begin
            sa  <= bus.a;
            sb  <= bus.b;
            acc <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            acc <= {d, acc[WIDTH-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                diff_q <= {d, acc[WIDTH-1:1]};
                bor_q  <= br_n;
            end
        end
    end

    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bor       = bor_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH = 8): reset, arithmetic, ignored starts,
// back-to-back issue and reset during an operation.
module tb_serial_sub;
    localparam int W = 8;
    localparam int LOG_N = 64;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    logic         busy_log [LOG_N];
    logic         done_log [LOG_N];
    logic [W-1:0] diff_log [LOG_N];
    logic         bor_log  [LOG_N];
    int           busy_n;
    int           done_n;
    int           overlap_n;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a sample point (1 ns after a rising edge); returns at the next one with start low.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Logs outputs for n cycles; optionally raises start for one cycle at index inj_at.
    task automatic watch(input int n, input int inj_at, input logic [W-1:0] ia, input logic [W-1:0] ib);
        busy_n    = 0;
        done_n    = 0;
        overlap_n = 0;
        for (int i = 0; i < n; i++) begin
            busy_log[i] = bus.busy;
            done_log[i] = bus.done;
            diff_log[i] = bus.diff;
            bor_log[i]  = bus.bor;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) done_n++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) overlap_n++;
            if (i == inj_at) begin
                bus.start = 1'b1;
                bus.a     = ia;
                bus.b     = ib;
            end else if (i == inj_at + 1) begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests++; if (bus.diff !== 8'h00 || bus.bor !== 1'b0) begin failed++; $display("FAIL reset_result got %h/%b want 00/0", bus.diff, bus.bor); end
        tests++; if (bus.fsm_state !== 2'd0) begin failed++; $display("FAIL reset_state got %0d want 0", bus.fsm_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        issue(8'h5A, 8'h3C);
        watch(12, -1, 8'h00, 8'h00);
        tests++; if (busy_n !== 8) begin failed++; $display("FAIL basic_busy_len got %0d want 8", busy_n); end
        tests++; if (done_n !== 1 || done_log[8] !== 1'b1) begin failed++; $display("FAIL basic_done got count %0d at8 %b want 1/1", done_n, done_log[8]); end
        tests++; if (diff_log[8] !== 8'h1E || bor_log[8] !== 1'b0) begin failed++; $display("FAIL basic_result got %h/%b want 1e/0", diff_log[8], bor_log[8]); end
        tests++; if (diff_log[3] !== 8'h00) begin failed++; $display("FAIL basic_hold got %h want 00", diff_log[3]); end
        tests++; if (overlap_n !== 0) begin failed++; $display("FAIL basic_overlap got %0d want 0", overlap_n); end
    endtask

    task automatic test_borrow_wrap;
        issue(8'h00, 8'h01);
        watch(10, -1, 8'h00, 8'h00);
        tests++; if (done_log[8] !== 1'b1 || diff_log[8] !== 8'hFF || bor_log[8] !== 1'b1) begin failed++; $display("FAIL wrap_under got %b %h/%b want 1 ff/1", done_log[8], diff_log[8], bor_log[8]); end
        issue(8'hFF, 8'hFF);
        watch(10, -1, 8'h00, 8'h00);
        tests++; if (done_log[8] !== 1'b1 || diff_log[8] !== 8'h00 || bor_log[8] !== 1'b0) begin failed++; $display("FAIL wrap_equal got %b %h/%b want 1 00/0", done_log[8], diff_log[8], bor_log[8]); end
        tests++; if (diff_log[5] !== 8'hFF || bor_log[5] !== 1'b1) begin failed++; $display("FAIL wrap_hold got %h/%b want ff/1", diff_log[5], bor_log[5]); end
    endtask

    task automatic test_async_reset;
        issue(8'h00, 8'h01);
        watch(8, -1, 8'h00, 8'h00);
        tests++; if (bus.done !== 1'b1 || bus.diff !== 8'hFF) begin failed++; $display("FAIL areset_pre got %b %h want 1 ff", bus.done, bus.diff); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failed++; $display("FAIL areset_ctrl got done %b busy %b want 0 0", bus.done, bus.busy); end
        tests++; if (bus.diff !== 8'h00 || bus.bor !== 1'b0) begin failed++; $display("FAIL areset_result got %h/%b want 00/0", bus.diff, bus.bor); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_ignore_busy;
        issue(8'h10, 8'h01);
        watch(20, 2, 8'hAA, 8'h55);
        tests++; if (busy_n !== 8) begin failed++; $display("FAIL ignore_busy_len got %0d want 8", busy_n); end
        tests++; if (done_n !== 1 || done_log[8] !== 1'b1) begin failed++; $display("FAIL ignore_done got count %0d at8 %b want 1/1", done_n, done_log[8]); end
        tests++; if (diff_log[8] !== 8'h0F || bor_log[8] !== 1'b0) begin failed++; $display("FAIL ignore_result got %h/%b want 0f/0", diff_log[8], bor_log[8]); end
    endtask

    task automatic test_back_to_back;
        issue(8'h40, 8'h20);
        watch(24, 8, 8'h80, 8'h81);
        tests++; if (done_log[8] !== 1'b1 || diff_log[8] !== 8'h20 || bor_log[8] !== 1'b0) begin failed++; $display("FAIL b2b_first got %b %h/%b want 1 20/0", done_log[8], diff_log[8], bor_log[8]); end
        tests++; if (busy_log[9] !== 1'b1) begin failed++; $display("FAIL b2b_restart got %b want 1", busy_log[9]); end
        tests++; if (diff_log[12] !== 8'h20) begin failed++; $display("FAIL b2b_hold got %h want 20", diff_log[12]); end
        tests++; if (done_log[17] !== 1'b1 || diff_log[17] !== 8'hFF || bor_log[17] !== 1'b1) begin failed++; $display("FAIL b2b_second got %b %h/%b want 1 ff/1", done_log[17], diff_log[17], bor_log[17]); end
        tests++; if (done_n !== 2 || busy_n !== 16 || overlap_n !== 0) begin failed++; $display("FAIL b2b_counts got done %0d busy %0d ovl %0d want 2 16 0", done_n, busy_n, overlap_n); end
    endtask

    task automatic test_reset_mid_op;
        issue(8'h33, 8'h11);
        watch(3, -1, 8'h00, 8'h00);
        tests++; if (bus.busy !== 1'b1 || bus.diff !== 8'hFF) begin failed++; $display("FAIL midrst_pre got busy %b diff %h want 1 ff", bus.busy, bus.diff); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'h00 || bus.bor !== 1'b0) begin failed++; $display("FAIL midrst_zero got busy %b done %b %h/%b want 0 0 00/0", bus.busy, bus.done, bus.diff, bus.bor); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        watch(12, -1, 8'h00, 8'h00);
        tests++; if (done_n !== 0 || busy_n !== 0) begin failed++; $display("FAIL midrst_quiet got done %0d busy %0d want 0 0", done_n, busy_n); end
        issue(8'h33, 8'h11);
        watch(10, -1, 8'h00, 8'h00);
        tests++; if (done_log[8] !== 1'b1 || diff_log[8] !== 8'h22 || bor_log[8] !== 1'b0) begin failed++; $display("FAIL midrst_after got %b %h/%b want 1 22/0", done_log[8], diff_log[8], bor_log[8]); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_basic();
        test_borrow_wrap();
        test_async_reset();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
